// File: rtl/face_crop_scaler.sv
// Crop-and-decimate stage: captures an OUT_W x OUT_H grid (pitch STEP, origin X0/Y0) from the pixel stream
// into sequential buffer addresses, with optional 4-tap horizontal mean. Writes are registered (1 cycle), no backpressure.
module face_crop_scaler #(
  parameter int PIX_W  = 8,
  parameter int X0     = 160,
  parameter int Y0     = 0,
  parameter int STEP   = 48,
  parameter int OUT_W  = 20,
  parameter int OUT_H  = 20,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              avg_mode,
  input  logic              px_valid,
  input  logic [PIX_W-1:0]  px_data,
  input  logic [15:0]       X_Cont,
  input  logic [15:0]       Y_Cont,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PH_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(STEP - 1);
  localparam logic [15:0]       X_LO      = 16'(X0);
  localparam logic [15:0]       Y_LO      = 16'(Y0);
  localparam logic [15:0]       X_SPAN    = 16'(STEP * OUT_W);
  localparam logic [15:0]       Y_SPAN    = 16'(STEP * OUT_H);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(OUT_W * OUT_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              avg_q;
  logic [PH_W-1:0]   xph_q, yph_q, xph_cur, yph_cur, yph_adv;
  logic [15:0]       last_y_q, x_off, y_off;
  logic [PIX_W-1:0]  tap1_q, tap2_q, tap3_q, h1, h2, h3;
  logic [PIX_W+1:0]  sum;
  logic [ADDR_W-1:0] addr_cnt_q, idx;
  logic              sof, in_win, active, take, last, arm_cmd;

  assign sof     = px_valid && (X_Cont == 16'd0) && (Y_Cont == 16'd0);
  assign arm_cmd = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Phase of the current pixel: column phase restarts at X0, row phase at Y0 and steps once per row change.
  assign yph_adv = (yph_q == PH_LAST) ? '0 : yph_q + 1'b1;
  assign xph_cur = (X_Cont == X_LO) ? '0 : xph_q;
  assign yph_cur = (Y_Cont == Y_LO) ? '0 : ((Y_Cont != last_y_q) ? yph_adv : yph_q);

  // Wrapping offsets make a single compare cover both window bounds.
  assign x_off  = X_Cont - X_LO;
  assign y_off  = Y_Cont - Y_LO;
  assign in_win = px_valid && (x_off < X_SPAN) && (y_off < Y_SPAN) &&
                  (xph_cur == '0) && (yph_cur == '0);

  assign active = (state_q == S_CAPTURE) || ((state_q == S_ARM) && sof);
  assign idx    = sof ? '0 : addr_cnt_q;
  assign take   = active && in_win;
  assign last   = take && (idx == ADDR_LAST);

  // Tap history is zeroed at the start of every row so earlier rows never leak in.
  assign h1  = (X_Cont == 16'd0) ? '0 : tap1_q;
  assign h2  = (X_Cont == 16'd0) ? '0 : tap2_q;
  assign h3  = (X_Cont == 16'd0) ? '0 : tap3_q;
  assign sum = {2'b00, px_data} + {2'b00, h1} + {2'b00, h2} + {2'b00, h3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ARM;
      S_ARM:     if (sof)   state_d = last ? S_DONE : S_CAPTURE;
      S_CAPTURE: if (last)  state_d = S_DONE;
      S_DONE:    if (start) state_d = S_ARM;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_ARM) || (state_q == S_CAPTURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xph_q    <= '0;
      yph_q    <= '0;
      last_y_q <= '0;
      tap1_q   <= '0;
      tap2_q   <= '0;
      tap3_q   <= '0;
    end else if (px_valid) begin
      xph_q    <= (xph_cur == PH_LAST) ? '0 : xph_cur + 1'b1;
      yph_q    <= yph_cur;
      last_y_q <= Y_Cont;
      tap1_q   <= px_data;
      tap2_q   <= h1;
      tap3_q   <= h2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      addr_cnt_q <= '0;
      avg_q      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en <= take;
      if (take) begin
        wr_addr    <= idx;
        wr_data    <= avg_q ? sum[PIX_W+1:2] : px_data;
        addr_cnt_q <= idx + 1'b1;
      end else if (active && sof) begin
        addr_cnt_q <= '0;
      end
      if (arm_cmd) begin
        avg_q <= avg_mode;
        done  <= 1'b0;
        err   <= 1'b0;
      end else begin
        if (last)                            done <= 1'b1;
        if ((state_q == S_CAPTURE) && sof)   err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_face_crop_scaler.sv
// Bench for face_crop_scaler on a reduced geometry: grid outputs are predicted from the
// sampling rules applied to a stored frame image and compared write by write.
module tb_face_crop_scaler;

  localparam int PIX_W = 8, X0 = 2, Y0 = 2, STEP = 4, OUT_W = 5, OUT_H = 4, ADDR_W = 5;
  localparam int W = 26, H = 20, N = OUT_W * OUT_H;

  logic clk = 1'b0;
  logic rst, start, avg_mode, px_valid;
  logic [PIX_W-1:0]  px_data;
  logic [15:0]       X_Cont, Y_Cont;
  logic              wr_en, busy, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  always #5 clk = ~clk;

  face_crop_scaler #(
    .PIX_W(PIX_W), .X0(X0), .Y0(Y0), .STEP(STEP),
    .OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .avg_mode(avg_mode),
    .px_valid(px_valid), .px_data(px_data), .X_Cont(X_Cont), .Y_Cont(Y_Cont),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {int addr; int data;} wr_t;
  typedef struct {bit avg; int prev; int p0; int p1; int p2; int exp_d;} vec_t;

  int   checks = 0, failures = 0;
  int   done_at, busy_at_done;
  wr_t  got_q[$], exp_q[$];
  logic [7:0] pix [H][W];
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back('{int'(wr_addr), int'(wr_data)});
      if (done && done_at < 0) begin
        done_at      = got_q.size() - 1;
        busy_at_done = int'(busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pix[y][x] = 8'($urandom);
  endtask

  // Expected grid: sample (gx,gy) sits at (X0+STEP*gx, Y0+STEP*gy); mean uses up to 4 pixels ending there.
  task automatic build_exp(input bit avg);
    exp_q.delete();
    for (int gy = 0; gy < OUT_H; gy++)
      for (int gx = 0; gx < OUT_W; gx++) begin
        int x, y, s, d;
        x = X0 + STEP * gx;
        y = Y0 + STEP * gy;
        s = 0;
        for (int k = 0; k < 4; k++) if (x - k >= 0) s += pix[y][x-k];
        d = avg ? (s / 4) : int'(pix[y][x]);
        exp_q.push_back('{gy * OUT_W + gx, d});
      end
  endtask

  task automatic send(input int npx, input int start_at, input bit gaps);
    for (int i = 0; i < npx; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        px_valid = 1'b0;
        start    = 1'b0;
        tick();
      end
      px_valid = 1'b1;
      X_Cont   = 16'(i % W);
      Y_Cont   = 16'(i / W);
      px_data  = pix[i / W][i % W];
      start    = (i == start_at);
      tick();
    end
    px_valid = 1'b0;
    start    = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_start(input bit avg);
    start    = 1'b1;
    avg_mode = avg;
    tick();
    start    = 1'b0;
    avg_mode = 1'($urandom);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic compare_writes(input string tag);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), got_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_data[%0d]", tag, i), got_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; avg_mode = 1'b0; px_valid = 1'b0;
    px_data = '0; X_Cont = '0; Y_Cont = '0;
    done_at = -1; busy_at_done = -1;

    vecs[0] = '{1'b1, 255, 10, 20, 30, 15};
    vecs[1] = '{1'b1, 200, 255, 255, 255, 191};
    vecs[2] = '{1'b1, 0, 3, 3, 3, 2};
    vecs[3] = '{1'b0, 77, 11, 22, 99, 99};
    vecs[4] = '{1'b1, 255, 0, 0, 7, 1};

    repeat (2) tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // A full raster with no start command must write nothing.
    fill_rand();
    got_q.delete();
    send(H * W, -1, 1'b0);
    chk("nostart_writes", got_q.size(), 0);
    chk("nostart_busy", busy, 0);

    // First grid point (X0,Y0): taps reach back past x=0, previous row tail must not leak in.
    foreach (vecs[v]) begin
      reset_pulse();
      do_start(vecs[v].avg);
      fill_rand();
      pix[Y0-1][W-1] = 8'(vecs[v].prev);
      pix[Y0][0] = 8'(vecs[v].p0);
      pix[Y0][1] = 8'(vecs[v].p1);
      pix[Y0][2] = 8'(vecs[v].p2);
      got_q.delete();
      send(Y0 * W + X0 + 1, -1, 1'b0);
      chk($sformatf("vec%0d_nwr", v), got_q.size(), 1);
      chk($sformatf("vec%0d_addr", v), (got_q.size() > 0) ? got_q[0].addr : -1, 0);
      chk($sformatf("vec%0d_data", v), (got_q.size() > 0) ? got_q[0].data : -1, vecs[v].exp_d);
    end

    // Random frames chained through DONE; a start pulse mid-capture is ignored.
    reset_pulse();
    for (int f = 0; f < 3; f++) begin
      bit avg;
      avg = 1'($urandom);
      do_start(avg);
      chk($sformatf("f%0d_done_clr", f), done, 0);
      chk($sformatf("f%0d_busy_arm", f), busy, 1);
      fill_rand();
      build_exp(avg);
      got_q.delete();
      done_at = -1;
      send(H * W, 100, 1'b1);
      compare_writes($sformatf("f%0d", f));
      chk($sformatf("f%0d_done_at", f), done_at, N - 1);
      chk($sformatf("f%0d_busy_at_done", f), busy_at_done, 0);
      chk($sformatf("f%0d_done", f), done, 1);
      chk($sformatf("f%0d_busy", f), busy, 0);
      chk($sformatf("f%0d_err", f), err, 0);
      chk($sformatf("f%0d_addr_hold", f), wr_addr, N - 1);
    end

    // Frame abort: partial frame to row 8, then a new SOF restarts from address 0.
    do_start(1'b0);
    fill_rand();
    build_exp(1'b0);
    got_q.delete();
    done_at = -1;
    send(9 * W, -1, 1'b0);
    chk("abort_partial", got_q.size(), 10);
    chk("abort_err_before", err, 0);
    send(H * W, -1, 1'b1);
    begin
      wr_t tmp[$];
      for (int i = 0; i < 10; i++) tmp.push_back(exp_q[i]);
      for (int i = 0; i < N; i++) tmp.push_back(exp_q[i]);
      exp_q = tmp;
    end
    compare_writes("abort");
    chk("abort_err", err, 1);
    chk("abort_done_at", done_at, 10 + N - 1);
    do_start(1'b0);
    chk("restart_err_clr", err, 0);
    chk("restart_done_clr", done, 0);

    // Asynchronous reset part-way through a capture.
    fill_rand();
    got_q.delete();
    for (int i = 0; i < H * W && got_q.size() < 10; i++) begin
      px_valid = 1'b1;
      X_Cont   = 16'(i % W);
      Y_Cont   = 16'(i / W);
      px_data  = pix[i / W][i % W];
      tick();
    end
    px_valid = 1'b0;
    chk("midrst_reached", got_q.size(), 10);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();
    got_q.delete();
    send(H * W, -1, 1'b0);
    chk("postrst_writes", got_q.size(), 0);
    chk("postrst_busy", busy, 0);

    // Start coincident with SOF in IDLE only arms; the following frame is captured.
    fill_rand();
    build_exp(1'b0);
    avg_mode = 1'b0;
    got_q.delete();
    send(H * W, 0, 1'b0);
    chk("startsof_writes", got_q.size(), 0);
    chk("startsof_busy", busy, 1);
    done_at = -1;
    send(H * W, -1, 1'b1);
    compare_writes("startsof_next");
    chk("startsof_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
